// File: rtl/spm_pkg.sv
// rtl/spm_pkg.sv - shared state type and width helper for the serial-parallel multiplier
package spm_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } spm_state_t;

    function automatic int cnt_width(input int w);
        return $clog2(2 * w);
    endfunction

endpackage

// File: rtl/spm_csa_cell.sv
// rtl/spm_csa_cell.sv - one carry-save bit-slice of the serial-parallel multiplier row
// With TCMP=1 and neg_i set, the partial-product stream is negated bit-serially (two's-complement MSB weight).
module spm_csa_cell #(
    parameter bit TCMP = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    input  logic en_i,
    input  logic neg_i,
    input  logic x_i,
    input  logic y_i,
    input  logic sin_i,
    output logic sum_o
);

    logic hsum1_q;
    logic hsum2_q, hsum2_d;
    logic carry_q, carry_d;
    logic pp, pp_eff;

    always_comb begin
        pp      = x_i & y_i;
        pp_eff  = pp;
        hsum2_d = hsum2_q;
        // Serial negation: invert every bit after the first 1 has passed.
        if (TCMP && neg_i) begin
            pp_eff  = pp ^ hsum2_q;
            hsum2_d = hsum2_q | pp;
        end
        sum_o   = pp_eff ^ hsum1_q ^ carry_q;
        carry_d = (pp_eff & hsum1_q) | (pp_eff & carry_q) | (hsum1_q & carry_q);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hsum1_q <= 1'b0;
            hsum2_q <= 1'b0;
            carry_q <= 1'b0;
        end else if (clr_i) begin
            hsum1_q <= 1'b0;
            hsum2_q <= 1'b0;
            carry_q <= 1'b0;
        end else if (en_i) begin
            hsum1_q <= sin_i;
            hsum2_q <= hsum2_d;
            carry_q <= carry_d;
        end
    end

endmodule

// File: rtl/spm_mult_hs.sv
// rtl/spm_mult_hs.sv - handshaked serial-parallel multiplier, signed/unsigned, serial and parallel product
module spm_mult_hs
    import spm_pkg::*;
#(
    parameter int WIDTH = 8,
    localparam int CNT_W = cnt_width(WIDTH)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_x,
    input  logic [WIDTH-1:0]   in_y,
    input  logic               in_signed,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] out_p,
    output logic               out_ser,
    output logic               busy
);

    localparam int PW = 2 * WIDTH;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PW - 1);

    spm_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] x_q, x_d;
    logic [WIDTH-1:0] y_q, y_d;
    logic             mode_q, mode_d;
    logic [PW-1:0]    p_q, p_d;
    logic             accept;
    logic             run;
    logic [WIDTH:0]   sum_w;

    assign run          = (state_q == RUN);
    assign in_ready     = (state_q == IDLE) || ((state_q == DONE) && out_ready);
    assign accept       = in_valid && in_ready;
    assign sum_w[WIDTH] = 1'b0;

    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_cell
        spm_csa_cell #(
            .TCMP (gi == WIDTH - 1)
        ) u_cell (
            .clk   (clk),
            .rst   (rst),
            .clr_i (accept),
            .en_i  (run),
            .neg_i (mode_q),
            .x_i   (x_q[gi]),
            .y_i   (y_q[0]),
            .sin_i (sum_w[gi+1]),
            .sum_o (sum_w[gi])
        );
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        x_d     = x_q;
        y_d     = y_q;
        mode_d  = mode_q;
        p_d     = p_q;
        unique case (state_q)
            IDLE: begin
                if (accept) state_d = RUN;
            end
            RUN: begin
                // Arithmetic shift in signed mode gives sign extension of y beyond WIDTH bits.
                y_d = {mode_q & y_q[WIDTH-1], y_q[WIDTH-1:1]};
                p_d = {sum_w[0], p_q[PW-1:1]};
                if (cnt_q == CNT_LAST) begin
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DONE: begin
                if (out_ready) state_d = in_valid ? RUN : IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (accept) begin
            x_d    = in_x;
            y_d    = in_y;
            mode_d = in_signed;
            cnt_d  = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            x_q     <= '0;
            y_q     <= '0;
            mode_q  <= 1'b0;
            p_q     <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            x_q     <= x_d;
            y_q     <= y_d;
            mode_q  <= mode_d;
            p_q     <= p_d;
        end
    end

    assign out_valid = (state_q == DONE);
    assign out_p     = p_q;
    assign out_ser   = run & sum_w[0];
    assign busy      = run;

endmodule
